// File: rtl/ms_timer.sv
// Millisecond one-shot timer with wrap-safe deadline compare and a small register map.
// Optional periodic auto-reload is built only when MS_TIMER_PERIODIC_EN is defined.
module ms_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ms_count,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        fired_q, fired_d;
  logic [31:0] delay_q, delay_d;
  logic [31:0] deadline_q, deadline_d;
  logic [31:0] rdata_q, rdata_d;

  logic        ctrl_wr_s, start_s, stop_s, ack_s;
  logic [31:0] diff_s;
  logic        expired_s;
  logic        armed_s;
  logic        periodic_s;
  logic        reload_s;
  logic [31:0] remaining_s;
  logic        unused_s;

  assign ctrl_wr_s = wr_en && (addr == 2'd0);
  assign start_s   = ctrl_wr_s && wdata[0];
  assign stop_s    = ctrl_wr_s && wdata[1];
  assign ack_s     = ctrl_wr_s && wdata[2];
  assign unused_s  = ^wdata[31:3];

  // Signed difference keeps the compare correct across the 2^32 wrap.
  assign diff_s    = ms_count - deadline_q;
  assign expired_s = (state_q == ST_ARMED) && !diff_s[31];

`ifdef MS_TIMER_PERIODIC_EN
  logic periodic_q, periodic_d;

  // Periodic mode bit, rewritten by every CTRL write.
  always_comb begin
    periodic_d = periodic_q;
    if (ctrl_wr_s) begin
      periodic_d = wdata[3];
    end else begin
      periodic_d = periodic_q;
    end
  end

  // Periodic mode register.
  always_ff @(posedge clk) begin
    if (reset) begin
      periodic_q <= 1'b0;
    end else begin
      periodic_q <= periodic_d;
    end
  end

  assign periodic_s = periodic_q;
`else
  assign periodic_s = 1'b0;
`endif

  // A zero delay in periodic mode would re-fire every cycle, so it degrades to one-shot.
  assign reload_s = periodic_s && (delay_q != 32'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and deadline: start beats stop, both beat expiry.
  always_comb begin
    state_d    = state_q;
    deadline_d = deadline_q;
    if (start_s) begin
      state_d    = ST_ARMED;
      deadline_d = ms_count + delay_q;
    end else if (stop_s) begin
      state_d = ST_IDLE;
    end else if (expired_s) begin
      if (reload_s) begin
        state_d    = ST_ARMED;
        deadline_d = deadline_q + delay_q;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State-decoded outputs.
  always_comb begin
    armed_s = 1'b0;
    case (state_q)
      ST_IDLE:  armed_s = 1'b0;
      ST_ARMED: armed_s = 1'b1;
      default:  armed_s = 1'b0;
    endcase
  end

  assign remaining_s = (armed_s && !expired_s) ? (deadline_q - ms_count) : 32'd0;

  // Fired flag (expiry beats ack), delay register and read mux.
  always_comb begin
    fired_d = fired_q;
    if (expired_s) begin
      fired_d = 1'b1;
    end else if (ack_s) begin
      fired_d = 1'b0;
    end else begin
      fired_d = fired_q;
    end

    delay_d = delay_q;
    if (wr_en && (addr == 2'd1)) begin
      delay_d = wdata;
    end else begin
      delay_d = delay_q;
    end

    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        2'd0:    rdata_d = {28'd0, periodic_s, 1'b0, fired_q, armed_s};
        2'd1:    rdata_d = delay_q;
        2'd2:    rdata_d = remaining_s;
        2'd3:    rdata_d = ms_count;
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fired_q    <= 1'b0;
      delay_q    <= 32'd0;
      deadline_q <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      fired_q    <= fired_d;
      delay_q    <= delay_d;
      deadline_q <= deadline_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = fired_q;

endmodule

// File: tb/tb_ms_timer.sv
// Directed self-checking bench for ms_timer; ms_count is stepped by hand so
// every expected value can be worked out from the deadline arithmetic.
module tb_ms_timer;

  logic        clk;
  logic        reset;
  logic [31:0] ms_count;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  ms_timer dut (
    .clk      (clk),
    .reset    (reset),
    .ms_count (ms_count),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr  = a;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check(tag, rdata, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; ms_count = 32'd0; wr_en = 1'b0; rd_en = 1'b0;
    addr = 2'd0; wdata = 32'd0;
    cyc(); cyc(); cyc();
    reset = 1'b0;
    chk_irq("reset_irq", 1'b0);
    check("reset_rdata", rdata, 32'd0);
    ms_count = 32'd50;
    rd(2'd0, 32'd0, "reset_ctrl");
    rd(2'd1, 32'd0, "reset_delay");
    rd(2'd2, 32'd0, "reset_remaining");
    ms_count = 32'h1234_5678;
    rd(2'd3, 32'h1234_5678, "snapshot");
    ms_count = 32'd60;
    cyc();
    check("rdata_hold", rdata, 32'h1234_5678);

    // One-shot: delay 5 started at 100 fires after ms_count 105
    ms_count = 32'd99;  wr(2'd1, 32'd5);
    ms_count = 32'd100; wr(2'd0, 32'd1);
    ms_count = 32'd101; cyc();
    ms_count = 32'd102; rd(2'd2, 32'd3, "oneshot_remaining");
    chk_irq("oneshot_irq_102", 1'b0);
    ms_count = 32'd103; cyc();
    ms_count = 32'd104; cyc();
    chk_irq("oneshot_irq_104", 1'b0);
    ms_count = 32'd105; cyc();
    chk_irq("oneshot_irq_105", 1'b1);
    ms_count = 32'd106; rd(2'd0, 32'h2, "oneshot_ctrl");
    ms_count = 32'd107; wr(2'd0, 32'd4);
    chk_irq("oneshot_ack", 1'b0);

    // Wrap: delay 10 from 0xFFFFFFFA gives deadline 4
    ms_count = 32'd108; wr(2'd1, 32'd10);
    ms_count = 32'hFFFF_FFFA; wr(2'd0, 32'd1);
    v = 32'hFFFF_FFFB;
    while (v != 32'd4) begin
      ms_count = v; cyc();
      chk_irq("wrap_no_fire", 1'b0);
      v = v + 32'd1;
    end
    ms_count = 32'd4; cyc();
    chk_irq("wrap_fire", 1'b1);
    ms_count = 32'd5; wr(2'd0, 32'd4);
    chk_irq("wrap_ack", 1'b0);

    // Collision: ack in the expiry cycle loses
    ms_count = 32'd9;  wr(2'd1, 32'd3);
    ms_count = 32'd10; wr(2'd0, 32'd1);
    ms_count = 32'd11; cyc();
    ms_count = 32'd12; cyc();
    chk_irq("coll_pre", 1'b0);
    ms_count = 32'd13; wr(2'd0, 32'd4);
    chk_irq("coll_expiry_wins", 1'b1);
    ms_count = 32'd14; rd(2'd0, 32'h2, "coll_ctrl");
    ms_count = 32'd15; wr(2'd0, 32'd4);
    chk_irq("coll_second_ack", 1'b0);
    ms_count = 32'd16; rd(2'd0, 32'h0, "coll_ctrl_clear");

    // Stop/restart, and DELAY write leaves an armed deadline alone
    ms_count = 32'd149; wr(2'd1, 32'd50);
    ms_count = 32'd150; wr(2'd0, 32'd1);
    ms_count = 32'd160; rd(2'd2, 32'd40, "stop_remaining_160");
    ms_count = 32'd170; wr(2'd0, 32'd2);
    for (int i = 171; i < 200; i++) begin
      ms_count = 32'(i); cyc();
      chk_irq("stop_no_irq", 1'b0);
    end
    ms_count = 32'd200; wr(2'd0, 32'd1);
    ms_count = 32'd210; rd(2'd2, 32'd40, "restart_remaining_210");
    ms_count = 32'd211; wr(2'd1, 32'd7);
    ms_count = 32'd212; rd(2'd2, 32'd38, "delay_wr_keeps_deadline");
    ms_count = 32'd213; rd(2'd1, 32'd7, "delay_readback");
    ms_count = 32'd214; wr(2'd0, 32'd2);
    ms_count = 32'd215; rd(2'd2, 32'd0, "idle_remaining");
    rd(2'd0, 32'h0, "idle_ctrl");
    ms_count = 32'd220; wr(2'd0, 32'd3);
    ms_count = 32'd221; rd(2'd0, 32'h1, "start_beats_stop");

    // Reset while armed cancels the timer
    ms_count = 32'd299; wr(2'd1, 32'd3);
    ms_count = 32'd300; wr(2'd0, 32'd1);
    ms_count = 32'd301; reset = 1'b1; cyc(); reset = 1'b0;
    chk_irq("rst_irq", 1'b0);
    check("rst_rdata", rdata, 32'd0);
    for (int i = 302; i <= 312; i++) begin
      ms_count = 32'(i); cyc();
      chk_irq("rst_no_irq", 1'b0);
    end
    rd(2'd0, 32'd0, "rst_ctrl");
    rd(2'd1, 32'd0, "rst_delay");
    rd(2'd2, 32'd0, "rst_remaining");

    // Simultaneous read/write returns the old value; writes to 2/3 ignored
    ms_count = 32'd320;
    addr = 2'd1; wdata = 32'd9; wr_en = 1'b1; rd_en = 1'b1;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rw_old_value", rdata, 32'd0);
    rd(2'd1, 32'd9, "rw_new_value");
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'h0000_0001);
    rd(2'd1, 32'd9, "ignored_wr_delay");
    rd(2'd0, 32'd0, "ignored_wr_ctrl");

    // Zero delay expires on the first armed cycle
    ms_count = 32'd400; wr(2'd1, 32'd0);
    wr(2'd0, 32'd1);
    chk_irq("zero_delay_start", 1'b0);
    ms_count = 32'd401; cyc();
    chk_irq("zero_delay_fire", 1'b1);
    rd(2'd0, 32'h2, "zero_delay_ctrl");
    wr(2'd0, 32'd4);

`ifdef MS_TIMER_PERIODIC_EN
    // Periodic: delay 4 from 0 fires at 4, 8, 12 and stays armed
    ms_count = 32'd0; wr(2'd1, 32'd4);
    wr(2'd0, 32'd9);
    for (int k = 1; k <= 3; k++) begin
      for (int j = 1; j < 4; j++) begin
        ms_count = 32'(4 * (k - 1) + j + ((k > 1) ? 1 : 0));
        if (ms_count[1:0] != 2'd0) begin
          cyc();
        end
      end
      chk_irq("periodic_pre", 1'b0);
      ms_count = 32'(4 * k); cyc();
      chk_irq("periodic_fire", 1'b1);
      ms_count = 32'(4 * k + 1);
      rd(2'd0, 32'hB, "periodic_ctrl");
      wr(2'd0, 32'hC);
      chk_irq("periodic_ack", 1'b0);
    end
    ms_count = 32'd13; rd(2'd2, 32'd3, "periodic_remaining");
    wr(2'd0, 32'd2);
`else
    ms_count = 32'd500; wr(2'd0, 32'd8);
    rd(2'd0, 32'h0, "periodic_ignored");
    wr(2'd0, 32'd9);
    rd(2'd0, 32'h1, "periodic_bit_zero");
    wr(2'd0, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
